// File: rtl/temp_spi_responder.sv
// SPI mode-0 responder that serves the latest temperature sample to an external master.
// Ports: clk/rst (sync, active-high); sample_d/sample_valid load the holding register;
//        sclk/cs_n from the master (oversampled); miso/miso_oe to the pad;
//        busy, frame_done/frame_abort pulses, fresh status.
module temp_spi_responder #(
    parameter int unsigned           DATA_WIDTH = 12,
    parameter int unsigned           LEAD_ZEROS = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_d,
    input  logic                  sample_valid,
    input  logic                  sclk,
    input  logic                  cs_n,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  fresh
);

    localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_WIDTH;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_RISE = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic                    fresh_q, fresh_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;

    // [0],[1] are the two synchronizer stages; [2] is the edge-detect copy.
    logic [2:0]              cs_sync_q;
    logic [2:0]              sclk_sync_q;

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b000;
        end else begin
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
        end
    end

    assign cs_fall   =  cs_sync_q[2]   & ~cs_sync_q[1];
    assign cs_rise   = ~cs_sync_q[2]   &  cs_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
    assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];

    // Holding register is independent of the frame; the shift register
    // takes its snapshot only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= RESET_VAL;
        end else if (sample_valid) begin
            hold_q <= sample_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            fresh_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fresh_d = fresh_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        miso    = 1'b0;
        miso_oe = 1'b0;

        unique case (state_q)
            IDLE: begin
                // sclk edges are ignored here, so a coincident sclk edge
                // is never counted against the new frame.
                if (cs_fall) begin
                    shift_d = {{LEAD_ZEROS{1'b0}}, hold_q};
                    cnt_d   = '0;
                    fresh_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                miso_oe = 1'b1;
                miso    = shift_q[FRAME_BITS-1];
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_RISE) begin
                        state_d = DONE;
                    end
                end else if (sclk_fall) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            DONE: begin
                miso_oe = 1'b1;
                if (cs_rise) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load in the frame-start cycle still leaves fresh set.
        if (sample_valid) begin
            fresh_d = 1'b1;
        end
    end

    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign fresh       = fresh_q;

endmodule

// File: tb/tb_temp_spi_responder.sv
// Self-checking bench for temp_spi_responder: a bench-side SPI master drives frames,
// expected frames go into a queue and a monitor checks them on frame_done/frame_abort.
module tb_temp_spi_responder;

    localparam int FRAME_BITS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_d;
    logic        sample_valid;
    logic        sclk;
    logic        cs_n;
    logic        miso;
    logic        miso_oe;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic        fresh;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] frame;
        int          n;
        bit          done;
        bit          fresh;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rx_word;
    logic [11:0] m_hold;
    bit          m_fresh;

    temp_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .sample_d     (sample_d),
        .sample_valid (sample_valid),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .fresh        (fresh)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every frame pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (frame_done || frame_abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {frame_done, frame_abort}, 2'b00);
            end else begin
                exp_t        e;
                logic [31:0] want;
                logic        b;
                e = exp_q.pop_front();
                want = '0;
                // Wire stream: the 16-bit frame MSB-first, then zeros.
                for (int i = 0; i < e.n; i++) begin
                    b = (i < FRAME_BITS) ? e.frame[FRAME_BITS-1-i] : 1'b0;
                    want = {want[30:0], b};
                end
                check("pulse_kind", {frame_done, frame_abort},
                      e.done ? 2'b10 : 2'b01);
                check("frame_bits", rx_word, want);
                check("fresh_at_end", fresh, e.fresh);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic load(input logic [11:0] v);
        @(negedge clk);
        sample_d     = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_hold  = v;
        m_fresh = 1'b1;
    endtask

    // One master frame with n rising edges; optional load exactly in the
    // frame-start cycle (cs_n edge seen through 2 sync flops + detect copy)
    // or in the middle of the frame.
    task automatic spi_frame(input int n, input bit ld_start,
                             input logic [11:0] v_start,
                             input bit ld_mid, input logic [11:0] v_mid);
        exp_t        e;
        logic [31:0] rx;
        bit          oe_bad;
        e.frame = {4'b0000, m_hold};
        e.n     = n;
        e.done  = (n >= FRAME_BITS);
        e.fresh = ld_start || ld_mid;
        exp_q.push_back(e);
        m_fresh = 1'b0;
        rx      = '0;
        oe_bad  = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        if (ld_start) begin
            @(negedge clk);
            @(negedge clk);
            sample_d     = v_start;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            m_hold  = v_start;
            m_fresh = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        if (ld_mid) begin
            load(v_mid);
        end
        for (int i = 0; i < n; i++) begin
            rx = {rx[30:0], miso};
            if (miso_oe !== 1'b1) oe_bad = 1'b1;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        rx_word = rx;
        check("oe_in_frame", oe_bad, 1'b0);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_after_frame", {busy, miso_oe, miso}, 3'b000);
    endtask

    initial begin
        rst          = 1'b1;
        sample_d     = '0;
        sample_valid = 1'b0;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        rx_word      = '0;
        m_hold       = '0;
        m_fresh      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {miso, miso_oe, busy, frame_done, frame_abort, fresh}, 6'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame and fresh handshake.
        load(12'h19A);
        check("fresh_after_load", fresh, 1'b1);
        spi_frame(16, 1'b0, '0, 1'b0, '0);
        check("fresh_cleared", fresh, m_fresh);

        // Aborts, then the held value survives intact.
        spi_frame(5, 1'b0, '0, 1'b0, '0);
        spi_frame(15, 1'b0, '0, 1'b0, '0);
        spi_frame(16, 1'b0, '0, 1'b0, '0);

        // Load in the frame-start cycle: old value goes out, new kept.
        load(12'h0C8);
        spi_frame(16, 1'b1, 12'h7FF, 1'b0, '0);
        spi_frame(16, 1'b0, '0, 1'b0, '0);

        // Reset in the middle of a frame.
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1;
            if (i == 7) break;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_frame",
              {miso_oe, busy, frame_done, frame_abort, miso}, 5'b0);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        m_hold  = '0;
        m_fresh = 1'b0;
        repeat (5) @(negedge clk);
        check("fresh_after_rst", fresh, 1'b0);
        spi_frame(16, 1'b0, '0, 1'b0, '0);

        // sclk activity while deselected is ignored.
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            check("idle_sclk_hi", {miso_oe, busy, miso}, 3'b000);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
        load(12'hA5C);
        spi_frame(16, 1'b0, '0, 1'b0, '0);

        // Extra rising edges after the last bit.
        load(12'hFFF);
        spi_frame(18, 1'b0, '0, 1'b0, '0);

        // Randomized frames, lengths across both sides of the boundary.
        for (int k = 0; k < 30; k++) begin
            int          n;
            bit          ls;
            bit          lm;
            logic [11:0] v1;
            logic [11:0] v2;
            n  = int'($urandom_range(0, 20));
            ls = ($urandom_range(0, 3) == 0);
            lm = ($urandom_range(0, 3) == 0);
            v1 = 12'($urandom);
            v2 = 12'($urandom);
            if ($urandom_range(0, 1) == 1) load(12'($urandom));
            spi_frame(n, ls, v1, lm, v2);
            check("fresh_between", fresh, m_fresh);
        end

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
